// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit
package lsu_pkg;
  localparam int LSU_XLEN = 32;
  localparam int XLEN_BYTES = LSU_XLEN / 8;
  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_t;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and store lane merge on one 32-bit word
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] word_i,
  input  logic [LSU_XLEN-1:0] wdata_i,
  input  logic [1:0]          off_i,
  input  logic [2:0]          funct3_i,
  output logic [LSU_XLEN-1:0] load_o,
  output logic [LSU_XLEN-1:0] store_o
);
  function automatic logic [LSU_XLEN-1:0] load_ext(input logic [LSU_XLEN-1:0] w, input logic [1:0] off,
                                                   input logic [2:0] f3);
    logic [LSU_XLEN-1:0] s;
    s = w >> {off, 3'b000};
    return f3 == LSU_B  ? {{24{s[7]}}, s[7:0]} :
           f3 == LSU_H  ? {{16{s[15]}}, s[15:0]} :
           f3 == LSU_BU ? {24'b0, s[7:0]} :
           f3 == LSU_HU ? {16'b0, s[15:0]} : w;
  endfunction

  function automatic logic [LSU_XLEN-1:0] store_merge(input logic [LSU_XLEN-1:0] old, input logic [LSU_XLEN-1:0] wd,
                                                      input logic [1:0] off, input logic [1:0] size);
    logic [XLEN_BYTES-1:0] m;
    logic [LSU_XLEN-1:0] s, r;
    m = size == 2'b00 ? XLEN_BYTES'(1) << off :
        size == 2'b01 ? XLEN_BYTES'(3) << {off[1], 1'b0} : '1;
    s = wd << {off, 3'b000};
    for (int i = 0; i < XLEN_BYTES; i++) r[8*i +: 8] = m[i] ? s[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign load_o  = load_ext(word_i, off_i, funct3_i);
  assign store_o = store_merge(word_i, wdata_i, off_i, funct3_i[1:0]);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 byte-addressed load/store front end for data_memory,
// with read-modify-write sub-word stores and misalign/out-of-range trapping.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = LSU_XLEN,
  parameter int ENTRY_COUNT = 1024,
  parameter int ADDR_WIDTH  = $clog2(ENTRY_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_misalign,
  output logic                  resp_oob,
  output logic [ADDR_WIDTH-1:0] mem_readAddr,
  output logic [ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [XLEN-1:0]       mem_writeData,
  output logic                  mem_writeEn,
  input  logic [XLEN-1:0]       mem_readData
);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * ENTRY_COUNT);

  lsu_state_t state_q, state_d;
  logic we_q, mis_q, oob_q;
  logic [2:0] f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [XLEN-1:0] wdata_q, rdata_q, load_data, store_data;
  logic accept, bad_f3, oob_d, mis_d;

  assign accept = req_valid && req_ready;
  assign bad_f3 = req_we ? req_funct3[2] | (&req_funct3[1:0]) : (&req_funct3[1:0]) | (&req_funct3[2:1]);
  assign oob_d  = bad_f3 || req_addr >= ADDR_LIMIT;
  // oob takes precedence, so misalign is only reported for in-range, legal funct3
  assign mis_d  = !oob_d && ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                             (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));

  always_comb state_d = state_q == IDLE ? (accept ? EXEC : IDLE) : state_q == EXEC ? RESP : IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[ADDR_WIDTH+1:0];
        wdata_q <= req_wdata;
        mis_q   <= mis_d;
        oob_q   <= oob_d;
      end
      if (state_q == EXEC) rdata_q <= !we_q && !mis_q && !oob_q ? load_data : '0;
    end
  end

  lsu_align u_align (
    .word_i   (mem_readData),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .load_o   (load_data),
    .store_o  (store_data)
  );

  assign req_ready     = state_q == IDLE;
  assign resp_valid    = state_q == RESP;
  assign resp_rdata    = rdata_q;
  assign resp_misalign = resp_valid && mis_q;
  assign resp_oob      = resp_valid && oob_q;
  assign mem_readAddr  = addr_q[ADDR_WIDTH+1:2];
  assign mem_writeAddr = addr_q[ADDR_WIDTH+1:2];
  assign mem_writeData = state_q == EXEC ? store_data : '0;
  // reset in EXEC must not let a half-finished store reach memory
  assign mem_writeEn   = rst_n && state_q == EXEC && we_q && !mis_q && !oob_q;
endmodule
